delta_index_encoder: RTL and testbench
======================================

Name: delta_index_encoder

Overview:
- Per-input-channel encoder that builds the compressed operand set a processing unit consumes.
- Takes one channel's weight stream, pre-sorted by the scheduler and paired with target output indices.
- Produces the base weight, a delta table (delta value plus similarity run length), and an index stream with stall entries and a terminator.
- Instantiated once per input channel between the weight-sort scheduler and the operand buffers.

Parameters:
BIN_LEN, 8, weight width (unsigned)
DELTA_LEN, 4, delta width (two's complement)
DELTA_SIM_LEN, 4, run-length field width
DELTA_NUM, 8, delta table depth
INDEX_WIDTH, 8, index entry width; MSB = stall flag
INDEX_NUM, 16, index stream depth

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  pulse; clears tables, begins a new encode
in_valid  in  1  input element valid
in_ready  out  1  encoder accepts element this cycle
in_weight  in  BIN_LEN  weight, non-decreasing within an encode
in_index  in  INDEX_WIDTH-1  target output index
in_skip  in  1  element is a stall request, not a weight
in_last  in  1  final element of the encode
weight_val  out  BIN_LEN  first weight of the encode
delta_vals  out  [DELTA_NUM][DELTA_LEN]  delta table values
delta_sims  out  [DELTA_NUM][DELTA_SIM_LEN]  run length per delta slot
index_vals  out  [INDEX_NUM][INDEX_WIDTH]  index stream
done  out  1  encode complete; outputs stable
error  out  1  overflow or range violation during this encode

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready=0.
- FSM states:
  - IDLE: wait for start; then go to FIRST.
  - FIRST: in_ready=1. The first non-skip element writes weight_val=in_weight, index_vals[0]={0,in_index}, prev=in_weight, and opens no delta slot. Go to RUN.
  - RUN: in_ready=1. Each accepted non-skip element computes d = in_weight - prev at BIN_LEN+1 bits.
    - If d matches the open slot and its sims < 2^DELTA_SIM_LEN-1: increment sims.
    - Otherwise open the next slot with value d and sims=1.
    - Append {0,in_index} to the index stream; set prev=in_weight.
  - FLUSH: one cycle, in_ready=0. Writes terminator {1,0...0} at the next index slot. Go to DONE.
  - DONE: done=1 and held until start or reset; start returns to FIRST with all tables cleared in the same cycle.
- Skip elements: in_skip with in_index=n (n>0) appends {1,n}, a stall of n cycles. n=0 is illegal: ignored and error=1. Skips do not touch prev or the delta table, and are legal in FIRST and RUN.
- in_last: on any accepted element, go to FLUSH after processing it.
- Handshake: transfer when in_valid && in_ready. in_ready is registered-state-only and does not depend on in_valid.
- Range error: d outside the signed DELTA_LEN range, or d<0 (unsorted input).
  - Set error=1, drop the element's delta contribution, still append its index.
- Index overflow: the terminator must always fit, so a data or skip entry is accepted only while the write pointer is < INDEX_NUM-1. Beyond that:
  - Further elements are consumed (in_ready stays 1), discarded, and error=1.
  - The terminator goes at the final slot.
- Delta overflow: opening slot DELTA_NUM sets error=1; the element is discarded while its index is still appended.
- Unused table slots read 0; unused index slots after the terminator read 0.
- Latency: each element is written one cycle after acceptance; done rises 2 cycles after the in_last transfer.
- start mid-encode: abort, clear, re-enter FIRST; error cleared.
- reset mid-encode: immediate return to the reset state.
- start and reset in the same cycle: reset wins.

Optional Feature:
STALL_MERGE_EN
- Defined: a skip directly following a stall entry adds to that entry's count in place when the sum is ≤ 2^(INDEX_WIDTH-1)-1; otherwise a new entry is appended.
- Undefined: every skip appends its own entry.

Test Plan:
1. start; weights 10,12,14,15 at indices 0,1,2,3, last on 15 -> weight_val=10; delta_vals[0]=2, sims[0]=2; delta_vals[1]=1, sims[1]=1; index_vals=00,01,02,03,80; done 2 cycles after the last transfer; error=0.
2. weights 5,5,5 then skip n=3, then weight 6 last -> delta[0]=0 sims 2; delta[1]=1 sims 1; index=00,01,02,83,03,80. With STALL_MERGE_EN, back-to-back skips 2,3 -> single entry 85.
3. weights 0,20 (DELTA_LEN=4) -> error=1; delta table empty; index=00,01,80.
4. 17 non-skip elements with INDEX_NUM=16 -> 15 data entries, terminator at slot 15, error=1, in_ready held 1 until last.
5. 16 elements with identical delta 1 (DELTA_SIM_LEN=4) -> sims[0]=15, sims[1]=0 (delta count 15 across 16 elements), no error; then start -> all outputs cleared, done=0 next cycle.
6. reset asserted mid-RUN with in_valid high -> next cycle all outputs 0, in_ready=0, state IDLE.

Source files
------------

// File: rtl/delta_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : delta_index_encoder
// Purpose  : Per-input-channel operand encoder. Consumes one channel's
//            weight stream (non-decreasing weights paired with target output
//            indices, optionally interleaved with stall requests) and builds
//            the compressed operand set: a base weight, a delta table of
//            (delta, run length) pairs and an index stream terminated by a
//            stall-flagged zero entry.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            start             - pulse; clears all tables, begins an encode
//            in_valid/in_ready - element handshake (in_ready is state-only)
//            in_weight         - weight, non-decreasing within an encode
//            in_index          - target output index, or stall count on skip
//            in_skip, in_last  - stall request / final element flags
//            weight_val        - first weight of the encode
//            delta_vals/sims   - delta table values and run lengths
//            index_vals        - index stream (MSB = stall flag)
//            done, error       - encode complete / sticky encode error
// Options  : STALL_MERGE_EN - when defined, back-to-back skips fold into the
//            preceding stall entry while the count still fits.
// Revision : 1.0 - initial release
// ============================================================================
module delta_index_encoder #(
   parameter int BIN_LEN       = 8,
   parameter int DELTA_LEN     = 4,
   parameter int DELTA_SIM_LEN = 4,
   parameter int DELTA_NUM     = 8,
   parameter int INDEX_WIDTH   = 8,
   parameter int INDEX_NUM     = 16
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      start,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [BIN_LEN-1:0]                        in_weight,
   input  logic [INDEX_WIDTH-2:0]                    in_index,
   input  logic                                      in_skip,
   input  logic                                      in_last,
   output logic [BIN_LEN-1:0]                        weight_val,
   output logic [DELTA_NUM-1:0][DELTA_LEN-1:0]       delta_vals,
   output logic [DELTA_NUM-1:0][DELTA_SIM_LEN-1:0]   delta_sims,
   output logic [INDEX_NUM-1:0][INDEX_WIDTH-1:0]     index_vals,
   output logic                                      done,
   output logic                                      error
);

   localparam int IP_W  = $clog2(INDEX_NUM);
   localparam int DS_W  = $clog2(DELTA_NUM);
   localparam int DC_W  = $clog2(DELTA_NUM + 1);
   localparam int CNT_W = INDEX_WIDTH - 1;

   localparam logic [BIN_LEN:0]       C_DELTA_MAX  = (BIN_LEN + 1)'(2 ** (DELTA_LEN - 1) - 1);
   localparam logic [DELTA_SIM_LEN-1:0] C_SIM_MAX  = {DELTA_SIM_LEN{1'b1}};
   localparam logic [INDEX_WIDTH-1:0] C_TERM       = {1'b1, {CNT_W{1'b0}}};
   localparam logic [IP_W-1:0]        C_LAST_SLOT  = IP_W'(INDEX_NUM - 1);
   localparam logic [DC_W-1:0]        C_DELTA_FULL = DC_W'(DELTA_NUM);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FIRST = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                                  state_q,  state_d;
   logic [IP_W-1:0]                         wptr_q,   wptr_d;
   logic [DC_W-1:0]                         dcnt_q,   dcnt_d;
   logic [BIN_LEN-1:0]                      prev_q,   prev_d;
   logic [BIN_LEN-1:0]                      weight_q, weight_d;
   logic [DELTA_NUM-1:0][DELTA_LEN-1:0]     dvals_q,  dvals_d;
   logic [DELTA_NUM-1:0][DELTA_SIM_LEN-1:0] dsims_q,  dsims_d;
   logic [INDEX_NUM-1:0][INDEX_WIDTH-1:0]   idx_q,    idx_d;
   logic                                    err_q,    err_d;
   logic                                    done_q,   done_d;

   logic                     w_xfer;
   logic [BIN_LEN:0]         w_diff;
   logic [DELTA_LEN-1:0]     w_delta;
   logic                     w_in_range;
   logic [DS_W-1:0]          w_open_slot;
   logic [DS_W-1:0]          w_new_slot;
   logic                     w_match;
   logic                     w_has_room;

`ifdef STALL_MERGE_EN
   logic                     stall_last_q, stall_last_d;
   logic [IP_W-1:0]          w_prev_slot;
   logic [CNT_W:0]           w_merge_sum;
   logic                     w_merge_ok;
`endif

   // Ready depends on state only, never on in_valid.
   assign in_ready = (state_q == S_FIRST) || (state_q == S_RUN);
   assign w_xfer   = in_valid && in_ready;

   // One extra bit so an unsorted (decreasing) weight shows up as negative.
   assign w_diff     = {1'b0, in_weight} - {1'b0, prev_q};
   assign w_delta    = w_diff[DELTA_LEN-1:0];
   assign w_in_range = !w_diff[BIN_LEN] && (w_diff <= C_DELTA_MAX);

   // The open slot is the most recently opened one (dcnt_q - 1).
   assign w_open_slot = DS_W'(dcnt_q - 1'b1);
   assign w_new_slot  = DS_W'(dcnt_q);
   assign w_match     = (dcnt_q != '0) &&
                        (dvals_q[w_open_slot] == w_delta) &&
                        (dsims_q[w_open_slot] != C_SIM_MAX);

   // The last slot is reserved so the terminator always fits.
   assign w_has_room  = (wptr_q < C_LAST_SLOT);

`ifdef STALL_MERGE_EN
   assign w_prev_slot = wptr_q - 1'b1;
   assign w_merge_sum = {1'b0, idx_q[w_prev_slot][CNT_W-1:0]} + {1'b0, in_index};
   // No carry out of the count field means the sum still fits.
   assign w_merge_ok  = stall_last_q && !w_merge_sum[CNT_W];
`endif

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      dcnt_d   = dcnt_q;
      prev_d   = prev_q;
      weight_d = weight_q;
      dvals_d  = dvals_q;
      dsims_d  = dsims_q;
      idx_d    = idx_q;
      err_d    = err_q;
      done_d   = done_q;
`ifdef STALL_MERGE_EN
      stall_last_d = stall_last_q;
`endif

      case (state_q)
         S_IDLE: begin
         end

         S_FIRST, S_RUN: begin
            if (w_xfer) begin
               if (in_skip) begin
                  if (in_index == '0) begin
                     // A zero-length stall is meaningless: drop it.
                     err_d = 1'b1;
                  end
`ifdef STALL_MERGE_EN
                  else if (w_merge_ok) begin
                     idx_d[w_prev_slot] = {1'b1, w_merge_sum[CNT_W-1:0]};
                  end
`endif
                  else if (w_has_room) begin
                     idx_d[wptr_q] = {1'b1, in_index};
                     wptr_d        = wptr_q + 1'b1;
`ifdef STALL_MERGE_EN
                     stall_last_d  = 1'b1;
`endif
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (!w_has_room) begin
                  // Index stream full: consume and discard the element.
                  err_d = 1'b1;
               end else begin
                  idx_d[wptr_q] = {1'b0, in_index};
                  wptr_d        = wptr_q + 1'b1;
                  prev_d        = in_weight;
`ifdef STALL_MERGE_EN
                  stall_last_d  = 1'b0;
`endif
                  if (state_q == S_FIRST) begin
                     // Base weight; no delta slot is opened for it.
                     weight_d = in_weight;
                     state_d  = S_RUN;
                  end else if (!w_in_range) begin
                     err_d = 1'b1;
                  end else if (w_match) begin
                     dsims_d[w_open_slot] = dsims_q[w_open_slot] + 1'b1;
                  end else if (dcnt_q == C_DELTA_FULL) begin
                     err_d = 1'b1;
                  end else begin
                     dvals_d[w_new_slot] = w_delta;
                     dsims_d[w_new_slot] = DELTA_SIM_LEN'(1);
                     dcnt_d              = dcnt_q + 1'b1;
                  end
               end

               if (in_last) begin
                  state_d = S_FLUSH;
               end
            end
         end

         S_FLUSH: begin
            idx_d[wptr_q] = C_TERM;
            done_d        = 1'b1;
            state_d       = S_DONE;
         end

         S_DONE: begin
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // start overrides everything (an element offered in the same cycle is
      // dropped) and clears the tables so the new encode begins from zero.
      if (start) begin
         state_d  = S_FIRST;
         wptr_d   = '0;
         dcnt_d   = '0;
         prev_d   = '0;
         weight_d = '0;
         dvals_d  = '0;
         dsims_d  = '0;
         idx_d    = '0;
         err_d    = 1'b0;
         done_d   = 1'b0;
`ifdef STALL_MERGE_EN
         stall_last_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         dcnt_q   <= '0;
         prev_q   <= '0;
         weight_q <= '0;
         dvals_q  <= '0;
         dsims_q  <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef STALL_MERGE_EN
         stall_last_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         dcnt_q   <= dcnt_d;
         prev_q   <= prev_d;
         weight_q <= weight_d;
         dvals_q  <= dvals_d;
         dsims_q  <= dsims_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
         done_q   <= done_d;
`ifdef STALL_MERGE_EN
         stall_last_q <= stall_last_d;
`endif
      end
   end

   assign weight_val = weight_q;
   assign delta_vals = dvals_q;
   assign delta_sims = dsims_q;
   assign index_vals = idx_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_delta_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_delta_index_encoder
// Purpose  : Directed self-checking bench for delta_index_encoder. Drives a
//            default-sized instance and a wide-index instance with the same
//            stimulus; each check targets whichever instance fits the case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delta_index_encoder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, start, in_valid, in_skip, in_last;
   logic [7:0] in_weight;
   logic [6:0] in_index;

   logic             n_ready, n_done, n_error;
   logic [7:0]       n_weight;
   logic [7:0][3:0]  n_dvals, n_dsims;
   logic [15:0][7:0] n_idx;

   logic             w_ready, w_done, w_error;
   logic [7:0]       w_weight;
   logic [7:0][3:0]  w_dvals, w_dsims;
   logic [31:0][7:0] w_idx;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0][7:0] exp_n;
   logic [31:0][7:0] exp_w;
   int ov_w [10] = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 13};

   delta_index_encoder u_dut (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(n_ready), .in_weight(in_weight), .in_index(in_index),
      .in_skip(in_skip), .in_last(in_last), .weight_val(n_weight),
      .delta_vals(n_dvals), .delta_sims(n_dsims), .index_vals(n_idx),
      .done(n_done), .error(n_error)
   );

   delta_index_encoder #(.INDEX_NUM(32)) u_wide (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(w_ready), .in_weight(in_weight), .in_index(in_index),
      .in_skip(in_skip), .in_last(in_last), .weight_val(w_weight),
      .delta_vals(w_dvals), .delta_sims(w_dsims), .index_vals(w_idx),
      .done(w_done), .error(w_error)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] w, input logic [6:0] idx, input logic sk, input logic lst);
      in_valid  = 1'b1;
      in_weight = w;
      in_index  = idx;
      in_skip   = sk;
      in_last   = lst;
      tick();
      in_valid  = 1'b0;
      in_skip   = 1'b0;
      in_last   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_skip = 1'b0;
      in_last = 1'b0; in_weight = '0; in_index = '0;
      tick();
      tick();
      chk("rst_ready",  n_ready,  0);
      chk("rst_done",   n_done,   0);
      chk("rst_error",  n_error,  0);
      chk("rst_weight", n_weight, 0);
      chk("rst_index",  n_idx,    0);
      reset = 1'b0;
      tick();
      chk("idle_ready", n_ready, 0);

      // Basic encode 10,12,14,15
      pulse_start();
      chk("first_ready", n_ready, 1);
      send(8'd10, 7'd0, 1'b0, 1'b0);
      send(8'd12, 7'd1, 1'b0, 1'b0);
      send(8'd14, 7'd2, 1'b0, 1'b0);
      send(8'd15, 7'd3, 1'b0, 1'b1);
      chk("t1_done_early", n_done, 0);
      tick();
      chk("t1_done",   n_done,   1);
      chk("t1_weight", n_weight, 8'd10);
      chk("t1_dvals",  n_dvals,  32'h0000_0012);
      chk("t1_dsims",  n_dsims,  32'h0000_0012);
      chk("t1_index",  n_idx,    128'h80_03_02_01_00);
      chk("t1_error",  n_error,  0);
      chk("t1_ready",  n_ready,  0);

      // Repeated weights with a stall in the middle
      pulse_start();
      send(8'd5, 7'd0, 1'b0, 1'b0);
      send(8'd5, 7'd1, 1'b0, 1'b0);
      send(8'd5, 7'd2, 1'b0, 1'b0);
      send(8'd0, 7'd3, 1'b1, 1'b0);
      send(8'd6, 7'd3, 1'b0, 1'b1);
      tick();
      chk("t2_dvals", n_dvals, 32'h0000_0010);
      chk("t2_dsims", n_dsims, 32'h0000_0012);
      chk("t2_index", n_idx,   128'h80_03_83_02_01_00);
      chk("t2_error", n_error, 0);

      // Back-to-back stalls
      pulse_start();
      send(8'd1, 7'd0, 1'b0, 1'b0);
      send(8'd0, 7'd2, 1'b1, 1'b0);
      send(8'd0, 7'd3, 1'b1, 1'b0);
      send(8'd2, 7'd1, 1'b0, 1'b1);
      tick();
`ifdef STALL_MERGE_EN
      chk("t2b_index", n_idx, 128'h80_01_85_00);
`else
      chk("t2b_index", n_idx, 128'h80_01_83_82_00);
`endif
      chk("t2b_dsims", n_dsims, 32'h0000_0001);

      // Zero-length stall in FIRST is dropped and flags an error
      pulse_start();
      send(8'd0, 7'd0, 1'b1, 1'b0);
      send(8'd4, 7'd5, 1'b0, 1'b1);
      tick();
      chk("t_skip0_error",  n_error,  1);
      chk("t_skip0_index",  n_idx,    128'h80_05);
      chk("t_skip0_weight", n_weight, 8'd4);

      // Delta too large
      pulse_start();
      chk("clr_error",  n_error,  0);
      chk("clr_done",   n_done,   0);
      chk("clr_weight", n_weight, 0);
      send(8'd0,  7'd0, 1'b0, 1'b0);
      send(8'd20, 7'd1, 1'b0, 1'b1);
      tick();
      chk("t3_error", n_error, 1);
      chk("t3_dvals", n_dvals, 0);
      chk("t3_dsims", n_dsims, 0);
      chk("t3_index", n_idx,   128'h80_01_00);

      // Largest legal delta (7) accepted, 8 rejected
      pulse_start();
      send(8'd0,  7'd0, 1'b0, 1'b0);
      send(8'd7,  7'd1, 1'b0, 1'b0);
      send(8'd15, 7'd2, 1'b0, 1'b1);
      tick();
      chk("t3b_dvals", n_dvals, 32'h0000_0007);
      chk("t3b_dsims", n_dsims, 32'h0000_0001);
      chk("t3b_error", n_error, 1);
      chk("t3b_index", n_idx,   128'h80_02_01_00);

      // Unsorted input
      pulse_start();
      send(8'd10, 7'd0, 1'b0, 1'b0);
      send(8'd8,  7'd1, 1'b0, 1'b1);
      tick();
      chk("t3c_error", n_error, 1);
      chk("t3c_dvals", n_dvals, 0);

      // Index overflow: 17 data elements into a 16-deep stream
      pulse_start();
      for (int i = 0; i < 17; i++) begin
         if (i == 16) chk("t4_ready_held", n_ready, 1);
         send(8'd0, 7'(i), 1'b0, (i == 16));
      end
      tick();
      exp_n = '0;
      for (int i = 0; i < 15; i++) exp_n[i] = 8'(i);
      exp_n[15] = 8'h80;
      chk("t4_index", n_idx,   exp_n);
      chk("t4_error", n_error, 1);
      chk("t4_dsims", n_dsims, 32'h0000_000E);

      // Delta table overflow: nine distinct runs into eight slots
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send(8'(ov_w[i]), 7'(i), 1'b0, (i == 9));
      end
      tick();
      chk("t_dovf_dvals", n_dvals,   32'h2121_2121);
      chk("t_dovf_dsims", n_dsims,   32'h1111_1111);
      chk("t_dovf_error", n_error,   1);
      chk("t_dovf_idx9",  n_idx[9],  8'h09);
      chk("t_dovf_idx10", n_idx[10], 8'h80);

      // Run length saturation on the wide instance: 16 elements, delta 1
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 7'(i), 1'b0, (i == 15));
      end
      tick();
      exp_w = '0;
      for (int i = 0; i < 16; i++) exp_w[i] = 8'(i);
      exp_w[16] = 8'h80;
      chk("t5_dsims", w_dsims, 32'h0000_000F);
      chk("t5_dvals", w_dvals, 32'h0000_0001);
      chk("t5_error", w_error, 0);
      chk("t5_done",  w_done,  1);
      chk("t5_ready", w_ready, 0);
      chk("t5_index", w_idx,   exp_w);
      pulse_start();
      chk("t5_clr_done",   w_done,   0);
      chk("t5_clr_dsims",  w_dsims,  0);
      chk("t5_clr_index",  w_idx,    0);
      chk("t5_clr_weight", w_weight, 0);

      // 17 elements: saturated slot forces a second slot
      for (int i = 0; i < 17; i++) begin
         send(8'(i), 7'(i), 1'b0, (i == 16));
      end
      tick();
      chk("t5b_dsims", w_dsims, 32'h0000_001F);
      chk("t5b_dvals", w_dvals, 32'h0000_0011);
      chk("t5b_error", w_error, 0);

      // Reset mid-RUN with an element on offer
      pulse_start();
      send(8'd1, 7'd0, 1'b0, 1'b0);
      in_valid = 1'b1; in_weight = 8'd3; in_index = 7'd1;
      reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("t6_ready",  n_ready,  0);
      chk("t6_weight", n_weight, 0);
      chk("t6_index",  n_idx,    0);
      chk("t6_dsims",  n_dsims,  0);
      chk("t6_done",   n_done,   0);
      tick();
      chk("t6_idle_ready", n_ready, 0);

      // start and reset together: reset wins
      start = 1'b1; reset = 1'b1;
      tick();
      start = 1'b0; reset = 1'b0;
      chk("t6_sr_ready", n_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
